thumb_fetch_unpacker: RTL

- Front end of the Thumb decode path.
- Accepts 32-bit instruction-fetch words and buffers them as halfwords.
- Emits one Thumb instruction per handshake, with its PC, to the Thumb-to-ARM transcoder.
- Merges a BL/BLX prefix+suffix pair into one 32-bit output so the transcoder can form a single ARM branch-with-link.

---
 rtl/thumb_pkg.sv | 29 ++
 rtl/thumb_hw_queue.sv | 54 +++++
 rtl/thumb_fetch_unpacker.sv | 101 ++++++++++
 3 files changed

// File: rtl/thumb_pkg.sv
// rtl/thumb_pkg.sv - shared types, BL/BLX decode constants and helpers for the Thumb fetch unpacker
package thumb_pkg;

   typedef logic [15:0] hw_t;

   localparam int DEFAULT_QDEPTH = 4;

   localparam logic [4:0] BL_PREFIX_MATCH = 5'b11110;
   localparam hw_t        BL_SUFFIX_MASK  = 16'hE800;
   localparam hw_t        BL_SUFFIX_MATCH = 16'hE800;

   localparam logic [31:0] PC_INC_SINGLE = 32'd2;
   localparam logic [31:0] PC_INC_PAIR   = 32'd4;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_PARTIAL,
      ST_READY
   } state_t;

   function automatic logic is_prefix(input hw_t hw);
      return hw[15:11] == BL_PREFIX_MATCH;
   endfunction

   function automatic logic is_suffix(input hw_t hw);
      return (hw & BL_SUFFIX_MASK) == BL_SUFFIX_MATCH;
   endfunction

endpackage

// File: rtl/thumb_hw_queue.sv
// rtl/thumb_hw_queue.sv - halfword circular FIFO, 2-wide write, 3-deep peek, pop-1/pop-2, clear
module thumb_hw_queue
   import thumb_pkg::*;
#(
   parameter int  QDEPTH = DEFAULT_QDEPTH,
   localparam int PW     = $clog2(QDEPTH),
   localparam int CW     = PW + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic [1:0]      push_num,
   input  hw_t  [1:0]      push_data,
   input  logic [1:0]      pop_num,
   output hw_t  [2:0]      peek,
   output logic [CW-1:0]   count
);

   hw_t           mem [QDEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + PW'(push_num);
         rd_ptr <= rd_ptr + PW'(pop_num);
         count  <= count + CW'(push_num) - CW'(pop_num);
      end
   end

   // Storage needs no reset: count gates every consumer of the contents.
   always_ff @(posedge clk) begin
      if (!clear) begin
         if (push_num != 2'd0) mem[wr_ptr] <= push_data[0];
         if (push_num == 2'd2) mem[wr_ptr + PW'(1)] <= push_data[1];
      end
   end

   always_comb begin
      peek = '0;
      for (int k = 0; k < 3; k++) begin
         peek[k] = mem[rd_ptr + PW'(k)];
      end
   end

endmodule

// File: rtl/thumb_fetch_unpacker.sv
// rtl/thumb_fetch_unpacker.sv - splits fetch words into Thumb instructions, merging BL/BLX pairs
module thumb_fetch_unpacker
   import thumb_pkg::*;
#(
   parameter int          QDEPTH   = DEFAULT_QDEPTH,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   input  logic        fetch_valid,
   output logic        fetch_ready,
   input  logic [31:0] fetch_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_code,
   output logic        out_pair,
   output logic [31:0] out_pc
);

   localparam int CW = $clog2(QDEPTH) + 1;

   state_t        state;
   state_t        state_next;
   logic [31:0]   pc_r;
   logic          drop_first;
   logic [CW-1:0] count;
   logic [CW-1:0] remain;
   logic [CW-1:0] count_next;
   hw_t  [2:0]    peek;
   hw_t  [1:0]    push_data;
   hw_t           next_head;
   logic [1:0]    push_num;
   logic [1:0]    pop_num;
   logic          accept;
   logic          pair;
   logic          handshake;

   thumb_hw_queue #(.QDEPTH(QDEPTH)) u_queue (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .push_num  (push_num),
      .push_data (push_data),
      .pop_num   (pop_num),
      .peek      (peek),
      .count     (count)
   );

   assign fetch_ready  = !flush && ((CW'(QDEPTH) - count) >= CW'(2));
   assign accept       = fetch_valid && fetch_ready;
   assign push_num     = !accept ? 2'd0 : (drop_first ? 2'd1 : 2'd2);
   assign push_data[0] = drop_first ? fetch_data[31:16] : fetch_data[15:0];
   assign push_data[1] = fetch_data[31:16];
   assign pair         = is_prefix(peek[0]) && (count >= CW'(2)) && is_suffix(peek[1]);
   assign out_pc       = pc_r;

   // Next state looks ahead at the head the queue will present after this cycle's pop/push.
   always_comb begin
      out_valid  = (state == ST_READY) && !flush;
      handshake  = out_valid && out_ready;
      pop_num    = !handshake ? 2'd0 : (pair ? 2'd2 : 2'd1);
      out_pair   = 1'b0;
      out_code   = '0;
      if (out_valid) begin
         out_pair = pair;
         out_code = pair ? {peek[0], peek[1]} : {16'h0000, peek[0]};
      end
      remain     = count - CW'(pop_num);
      count_next = remain + CW'(push_num);
      if (remain == '0)          next_head = push_data[0];
      else if (pop_num == 2'd2)  next_head = peek[2];
      else if (pop_num == 2'd1)  next_head = peek[1];
      else                       next_head = peek[0];
      state_next = ST_READY;
      if (flush || count_next == '0) begin
         state_next = ST_EMPTY;
      end else if (count_next == CW'(1) && is_prefix(next_head)) begin
         state_next = ST_PARTIAL;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_EMPTY;
         pc_r       <= RESET_PC & ~32'h1;
         drop_first <= RESET_PC[1];
      end else begin
         state <= state_next;
         if (flush) begin
            pc_r       <= flush_pc & ~32'h1;
            drop_first <= flush_pc[1];
         end else begin
            if (handshake) pc_r <= pc_r + (pair ? PC_INC_PAIR : PC_INC_SINGLE);
            if (accept)    drop_first <= 1'b0;
         end
      end
   end

endmodule
